// File: rtl/csr_file_if.sv
// CSR read/write bus between the pipeline (execute reads, commit writes) and the CSR file.
// Read channel has no backpressure; write channel is a request/response handshake.
interface csr_file_if;
  logic [11:0] araddr;
  logic        arvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [2:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, waddr, wdata, wvalid, bready,
    input  rdata, rresp, rvalid, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, waddr, wdata, wvalid, bready,
    output rdata, rresp, rvalid, wready, bresp, bvalid
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: csrbus read/write responder, trap state capture (mepc/mcause/mtval)
// and the 64-bit mcycle/minstret counters.
module csr_file #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic         clk,
  input  logic         reset,
  csr_file_if.slave    csrbus,
  input  logic         instret_inc,
  input  logic         exception_valid_in,
  input  logic [31:0]  exception_mepc_in,
  input  logic [31:0]  exception_mcause_in,
  input  logic [31:0]  exception_mtval_in,
  output logic [29:0]  exception_mtvec_base_out,
  output logic [31:0]  exception_mepc_out
);

  typedef enum logic {W_IDLE, W_RESP} w_state_e;

  w_state_e    w_state_q, w_state_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [2:0]  bresp_q, bresp_d;
  logic        mie_q, mie_d, mpie_q, mpie_d;
  logic [29:0] mtvec_q, mtvec_d;
  logic [29:0] mepc_q, mepc_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  logic [31:0] mstatus_view;
  logic [31:0] rd_val;
  logic        rd_ok;
  logic        wr_accept, wr_okay, wr_en;

  // MPP is hardwired to machine mode; only MIE and MPIE are stored.
  assign mstatus_view = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    rd_val = 32'h0;
    rd_ok  = 1'b1;
    case (csrbus.araddr)
      12'h300:          rd_val = mstatus_view;
      12'h301:          rd_val = MISA_VALUE;
      12'h305:          rd_val = {mtvec_q, 2'b00};
      12'h340:          rd_val = mscratch_q;
      12'h341:          rd_val = {mepc_q, 2'b00};
      12'h342:          rd_val = mcause_q;
      12'h343:          rd_val = mtval_q;
      12'hB00, 12'hC00: rd_val = mcycle_q[31:0];
      12'hB80, 12'hC80: rd_val = mcycle_q[63:32];
      12'hB02, 12'hC02: rd_val = minstret_q[31:0];
      12'hB82, 12'hC82: rd_val = minstret_q[63:32];
      12'hF11, 12'hF12, 12'hF13: rd_val = 32'h0;
      12'hF14:          rd_val = HART_ID;
      default:          rd_ok  = 1'b0;
    endcase
  end

  always_comb begin
    rvalid_d = csrbus.arvalid;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (csrbus.arvalid) begin
      rdata_d = rd_ok ? rd_val : 32'h0;
      rresp_d = rd_ok ? 2'b00 : 2'b10;
    end
  end

  // Only these addresses accept writes; everything in 0xCxx-0xFxx is read-only.
  always_comb begin
    case (csrbus.waddr)
      12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
      12'hB00, 12'hB80, 12'hB02, 12'hB82: wr_okay = 1'b1;
      default:                            wr_okay = 1'b0;
    endcase
  end

  assign wr_accept = (w_state_q == W_IDLE) && csrbus.wvalid;
  assign wr_en     = wr_accept && wr_okay;
  assign bresp_d   = wr_accept ? (wr_okay ? 3'b000 : 3'b010) : bresp_q;

  // Write FSM: next-state logic.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (csrbus.wvalid) w_state_d = W_RESP;
      W_RESP:  if (csrbus.bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM: outputs.
  always_comb begin
    csrbus.wready = (w_state_q == W_IDLE);
    csrbus.bvalid = (w_state_q == W_RESP);
  end

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'b0, instret_inc};
    if (wr_en) begin
      case (csrbus.waddr)
        12'h300: begin
          mie_d  = csrbus.wdata[3];
          mpie_d = csrbus.wdata[7];
        end
        12'h305: mtvec_d    = csrbus.wdata[31:2];
        12'h340: mscratch_d = csrbus.wdata;
        12'h341: mepc_d     = csrbus.wdata[31:2];
        12'h342: mcause_d   = csrbus.wdata;
        12'h343: mtval_d    = csrbus.wdata;
        // A written half takes the bus value; the carry between halves is dropped that cycle.
        12'hB00: mcycle_d   = {mcycle_q[63:32], csrbus.wdata};
        12'hB80: mcycle_d   = {csrbus.wdata, mcycle_q[31:0] + 32'd1};
        12'hB02: minstret_d = {minstret_q[63:32], csrbus.wdata};
        12'hB82: minstret_d = {csrbus.wdata, minstret_q[31:0] + {31'b0, instret_inc}};
        default: ;
      endcase
    end
    // Trap capture is applied last so it overrides a same-cycle write to the trap CSRs.
    if (exception_valid_in) begin
      mepc_d   = exception_mepc_in[31:2];
      mcause_d = exception_mcause_in;
      mtval_d  = exception_mtval_in;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q  <= W_IDLE;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0;
      rresp_q    <= 2'b00;
      bresp_q    <= 3'b000;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET[31:2];
      mscratch_q <= 32'h0;
      mepc_q     <= 30'h0;
      mcause_q   <= 32'h0;
      mtval_q    <= 32'h0;
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      w_state_q  <= w_state_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      bresp_q    <= bresp_d;
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign csrbus.rvalid = rvalid_q;
  assign csrbus.rdata  = rdata_q;
  assign csrbus.rresp  = rresp_q;
  assign csrbus.bresp  = bresp_q;

  assign exception_mtvec_base_out = mtvec_q;
  assign exception_mepc_out       = {mepc_q, 2'b00};

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: stimulus pushes expected responses into queues, a negedge
// monitor pops and compares whenever the DUT presents a read or write response.
module tb_csr_file;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  typedef struct {
    logic [11:0] addr;
    logic [2:0]  resp;
  } wr_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instret_inc = 1'b0;
  logic        exception_valid_in = 1'b0;
  logic [31:0] exception_mepc_in = '0;
  logic [31:0] exception_mcause_in = '0;
  logic [31:0] exception_mtval_in = '0;
  logic [29:0] exception_mtvec_base_out;
  logic [31:0] exception_mepc_out;

  int checks = 0;
  int failures = 0;

  rd_exp_t rq[$];
  wr_exp_t wq[$];

  csr_file_if bus ();

  csr_file #(
    .MTVEC_RESET (32'h0000_1003),
    .MISA_VALUE  (32'h4000_0100),
    .HART_ID     (32'd5)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .csrbus                   (bus),
    .instret_inc              (instret_inc),
    .exception_valid_in       (exception_valid_in),
    .exception_mepc_in        (exception_mepc_in),
    .exception_mcause_in      (exception_mcause_in),
    .exception_mtval_in       (exception_mtval_in),
    .exception_mtvec_base_out (exception_mtvec_base_out),
    .exception_mepc_out       (exception_mepc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare every response the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rvalid) begin
        if (rq.size() == 0) begin
          check("rd_unexpected", {31'b0, bus.rvalid}, 32'd0);
        end else begin
          rd_exp_t e;
          e = rq.pop_front();
          check($sformatf("rd_data[%03h]", e.addr), bus.rdata, e.data);
          check($sformatf("rd_resp[%03h]", e.addr), {30'b0, bus.rresp}, {30'b0, e.resp});
        end
      end
      if (bus.bvalid && bus.bready) begin
        if (wq.size() == 0) begin
          check("wr_unexpected", {31'b0, bus.bvalid}, 32'd0);
        end else begin
          wr_exp_t w;
          w = wq.pop_front();
          check($sformatf("wr_bresp[%03h]", w.addr), {29'b0, bus.bresp}, {29'b0, w.resp});
        end
      end
    end
  end

  task automatic do_read(input logic [11:0] a, input logic [31:0] d, input logic [1:0] r);
    rq.push_back('{addr: a, data: d, resp: r});
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [2:0] r,
                          input int hold, input bit exc,
                          input logic [31:0] e_pc, input logic [31:0] e_cause,
                          input logic [31:0] e_val);
    int budget;
    budget = 0;
    while (!bus.wready && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    check("wready_wait", {31'b0, bus.wready}, 32'd1);
    wq.push_back('{addr: a, resp: r});
    bus.waddr  = a;
    bus.wdata  = d;
    bus.wvalid = 1'b1;
    bus.bready = 1'b0;
    if (exc) begin
      exception_valid_in  = 1'b1;
      exception_mepc_in   = e_pc;
      exception_mcause_in = e_cause;
      exception_mtval_in  = e_val;
    end
    @(posedge clk); #1;
    bus.wvalid         = 1'b0;
    exception_valid_in = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bvalid_held", {31'b0, bus.bvalid}, 32'd1);
      check("wready_low", {31'b0, bus.wready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.bready = 1'b1;
    budget = 0;
    @(negedge clk);
    while (!bus.bvalid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("bvalid_wait", {31'b0, bus.bvalid}, 32'd1);
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  initial begin
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.waddr   = '0;
    bus.wdata   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state and read-only identity registers
    @(negedge clk);
    check("rst_wready", {31'b0, bus.wready}, 32'd1);
    check("rst_bvalid", {31'b0, bus.bvalid}, 32'd0);
    check("rst_rvalid", {31'b0, bus.rvalid}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_mtvec_base", {2'b0, exception_mtvec_base_out}, 32'h0000_0400);
    @(posedge clk); #1;
    do_read(12'h305, 32'h0000_1000, 2'b00);
    do_read(12'h301, 32'h4000_0100, 2'b00);
    do_read(12'hF14, 32'd5, 2'b00);
    do_read(12'h300, 32'h0000_1800, 2'b00);
    do_read(12'hF12, 32'h0, 2'b00);

    // mepc write with stalled response, bits [1:0] forced to zero
    do_write(12'h341, 32'h8000_0007, 3'b000, 3, 1'b0, '0, '0, '0);
    check("mepc_out", exception_mepc_out, 32'h8000_0004);
    do_read(12'h341, 32'h8000_0004, 2'b00);

    // Read-only and unimplemented addresses
    do_write(12'hC80, 32'h0000_ABCD, 3'b010, 0, 1'b0, '0, '0, '0);
    do_write(12'h7C0, 32'h1234_5678, 3'b010, 0, 1'b0, '0, '0, '0);
    do_read(12'h7C0, 32'h0, 2'b10);
    do_read(12'hC80, 32'h0, 2'b00);

    // Plain read/write CSRs and mstatus write masking
    do_write(12'h340, 32'h1234_5678, 3'b000, 0, 1'b0, '0, '0, '0);
    do_write(12'h300, 32'hFFFF_FFFF, 3'b000, 0, 1'b0, '0, '0, '0);
    do_write(12'h301, 32'h0000_0000, 3'b000, 0, 1'b0, '0, '0, '0);
    do_write(12'h305, 32'h0000_2003, 3'b000, 1, 1'b0, '0, '0, '0);
    check("mtvec_base_out", {2'b0, exception_mtvec_base_out}, 32'h0000_0800);
    do_read(12'h340, 32'h1234_5678, 2'b00);
    do_read(12'h300, 32'h0000_1888, 2'b00);
    do_read(12'h301, 32'h4000_0100, 2'b00);
    do_read(12'h305, 32'h0000_2000, 2'b00);

    // minstret counts only retired-instruction cycles
    do_read(12'hB02, 32'h0, 2'b00);
    instret_inc = 1'b1;
    repeat (3) @(posedge clk);
    #1 instret_inc = 1'b0;
    do_read(12'hC02, 32'd3, 2'b00);
    do_read(12'hC82, 32'd0, 2'b00);

    // mcycle low-half wrap carries into the high half; back-to-back reads
    do_write(12'hB00, 32'hFFFF_FFFF, 3'b000, 0, 1'b0, '0, '0, '0);
    do_read(12'hB80, 32'd1, 2'b00);
    do_read(12'hB00, 32'd1, 2'b00);

    // Exception beats a same-cycle mepc write, write still reports OKAY
    do_write(12'h300, 32'h0000_0008, 3'b000, 0, 1'b0, '0, '0, '0);
    do_read(12'h300, 32'h0000_1808, 2'b00);
    do_write(12'h341, 32'h0000_0200, 3'b000, 0, 1'b1, 32'h0000_0100, 32'd2, 32'h0000_DEAD);
    check("exc_mepc_out", exception_mepc_out, 32'h0000_0100);
    do_read(12'h341, 32'h0000_0100, 2'b00);
    do_read(12'h342, 32'd2, 2'b00);
    do_read(12'h343, 32'h0000_DEAD, 2'b00);
    do_read(12'h300, 32'h0000_1880, 2'b00);

    // Reset while a write response is pending
    bus.waddr  = 12'h340;
    bus.wdata  = 32'h0000_0055;
    bus.wvalid = 1'b1;
    bus.bready = 1'b0;
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
    @(negedge clk);
    check("pre_rst_bvalid", {31'b0, bus.bvalid}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst2_bvalid", {31'b0, bus.bvalid}, 32'd0);
    check("rst2_wready", {31'b0, bus.wready}, 32'd1);
    check("rst2_rdata", bus.rdata, 32'd0);
    check("rst2_mepc_out", exception_mepc_out, 32'd0);
    check("rst2_mtvec_base", {2'b0, exception_mtvec_base_out}, 32'h0000_0400);
    @(posedge clk); #1;
    do_read(12'h340, 32'h0, 2'b00);
    do_read(12'h341, 32'h0, 2'b00);
    do_read(12'h342, 32'h0, 2'b00);
    do_read(12'h343, 32'h0, 2'b00);
    do_read(12'h300, 32'h0000_1800, 2'b00);
    do_read(12'h305, 32'h0000_1000, 2'b00);
    do_read(12'hB80, 32'h0, 2'b00);
    do_read(12'hB02, 32'h0, 2'b00);

    repeat (3) @(posedge clk);
    #1;
    check("rd_queue_drained", rq.size(), 32'd0);
    check("wr_queue_drained", wq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
